psr_unit: RTL and testbench
===========================

# psr_unit

Program Status Register unit for the CPU core: holds the architectural arithmetic flags (carry, zero, negative) that the ALU produces. It feeds the current flags back to the ALU as carry-in and status, and evaluates branch conditions against them with same-cycle forwarding. It also saves and restores the flags on a small shadow stack for interrupt entry and exit.

## Interface
- `APSR_W`, default `` `APSR_WIDTH `` (3): flag vector width. Bit positions are `` `APSR_CARRY ``, `` `APSR_ZERO `` and `` `APSR_NEG ``.
- `DEPTH`, default 2: shadow stack entries, minimum 1.
- `clk` in, 1: core clock. All state changes on its rising edge.
- `rst_n` in, 1: asynchronous, active-low reset.
- `apsr_i` in, `APSR_W`: flags from the ALU.
- `apsr_we_i` in, 1: latch `apsr_i` into the PSR.
- `psr_o` out, `APSR_W`: current registered PSR, sent to the ALU `psr` input.
- `br_req_i` in, 1: branch condition evaluation request.
- `br_cond_i` in, 3: condition code.
- `br_valid_o` out, 1: registered; evaluation result valid.
- `br_taken_o` out, 1: registered; condition true.
- `irq_save_i` in, 1: push PSR onto the shadow stack.
- `irq_restore_i` in, 1: pop the shadow stack into the PSR.
- `stk_empty_o` out, 1: no saved entries.
- `stk_full_o` out, 1: `DEPTH` entries saved.
- `stk_err_o` out, 1: sticky overflow/underflow/illegal-request flag.
- `err_clr_i` in, 1: clear `stk_err_o`.

## Operation
- **PSR next-state priority** (highest first):
  1. A legal restore loads the top stack entry.
  2. Otherwise `apsr_we_i` loads `apsr_i`.
  3. Otherwise the PSR holds.
- **Condition codes**, evaluated by `br_cond_i` value:
  - 0 AL: always true.
  - 1 EQ: Z.
  - 2 NE: !Z.
  - 3 CS: C.
  - 4 CC: !C.
  - 5 MI: N.
  - 6 PL: !N.
  - 7 NV: never true.
- **Forwarding:** the condition is evaluated against the PSR next-state value, not `psr_o`. A flag-setting ALU op and a dependent branch may therefore issue in the same cycle.
- **Stack:** LIFO with an occupancy counter of `$clog2(DEPTH+1)` bits.
  - Save pushes the current registered `psr_o`. The pre-update value is pushed even if `apsr_we_i` is also high; the PSR still takes `apsr_i`.
  - Restore pops the top entry.
- **Save when full:** the push is dropped, the stack is unchanged, and `stk_err_o` is set.
- **Restore when empty:** the PSR follows the `apsr_we_i`/hold rule, the counter stays 0, and `stk_err_o` is set.
- **Save and restore in the same cycle:** illegal. The stack is unchanged, the PSR follows the `apsr_we_i`/hold rule, and `stk_err_o` is set.
- **Error flag:** `stk_err_o` is sticky. `err_clr_i` clears it. If a new error occurs in the same cycle as `err_clr_i`, the flag stays set.
- **Status outputs:** `stk_empty_o` and `stk_full_o` are decoded from the registered counter.

## Timing
- **Reset values** (asynchronous, immediate on `rst_n`=0):
  - `psr_o`=0, counter=0.
  - Stack entries=0.
  - `br_valid_o`=0, `br_taken_o`=0.
  - `stk_err_o`=0.
  - `stk_empty_o`=1, `stk_full_o`=0.
- Reset asserted mid-operation discards the PSR and all saved entries. No partial state survives.
- **PSR latency:** `apsr_we_i` or restore in cycle N → new `psr_o` visible from N+1.
- **Branch latency:** `br_req_i` in cycle N → `br_valid_o`=1 for exactly cycle N+1, with `br_taken_o` computed from the next-state PSR of cycle N.
  - `br_taken_o` is 0 whenever `br_valid_o` is 0.
  - Back-to-back requests give back-to-back valid pulses.
- **Stack latency:** a save or restore in cycle N updates the counter and `stk_empty_o`/`stk_full_o` at N+1.
- **Error latency:** an error in cycle N sets `stk_err_o` at N+1.
- No combinational path from any input to any output.

## Test plan
- **Reset and branch basics:** hold reset, release, then `br_req_i`=1 with cond=EQ → `psr_o`=0, `stk_empty_o`=1, next cycle `br_valid_o`=1 and `br_taken_o`=0. Cond=AL → taken=1; cond=NV → taken=0.
- **Forwarding:** in the same cycle, `apsr_we_i`=1 with `apsr_i`=Z set, plus `br_req_i` with cond=EQ → next cycle `br_taken_o`=1 and `psr_o` shows Z. Repeat with cond=NE → taken=0.
- **Save/restore round trip:** set PSR to C=1. Save while `apsr_we_i` loads N=1 → `psr_o`=N only and counter=1. Restore plus `br_req_i` with cond=CS in the same cycle → taken=1 and `psr_o`=C only.
- **Stack boundaries:** with `DEPTH`=2, three saves → `stk_full_o`=1 after the second save and `stk_err_o`=1 after the third. Two restores return entries LIFO. A third restore keeps the PSR unchanged and the error set. `err_clr_i` → error 0.
- **Illegal simultaneous request:** save and restore in the same cycle with 1 entry stacked → counter stays 1 and `stk_err_o`=1. `err_clr_i` plus a new underflow in the same cycle → error stays 1.
- **Asynchronous reset mid-stack:** assert `rst_n`=0 between clock edges with 2 entries stacked → all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/psr_unit.sv
// Program status register: C/Z/N flags, forwarded branch-condition evaluation and an IRQ shadow stack.
// Latency: 1 cycle for PSR, branch result, stack and error flag; no backpressure, every request is acted on or flagged in stk_err_o.

`ifndef APSR_WIDTH
`define APSR_WIDTH 3
`endif
`ifndef APSR_CARRY
`define APSR_CARRY 0
`endif
`ifndef APSR_ZERO
`define APSR_ZERO 1
`endif
`ifndef APSR_NEG
`define APSR_NEG 2
`endif

module psr_unit #(
    parameter int APSR_W = `APSR_WIDTH,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [APSR_W-1:0] apsr_i,
    input  logic              apsr_we_i,
    output logic [APSR_W-1:0] psr_o,
    input  logic              br_req_i,
    input  logic [2:0]        br_cond_i,
    output logic              br_valid_o,
    output logic              br_taken_o,
    input  logic              irq_save_i,
    input  logic              irq_restore_i,
    output logic              stk_empty_o,
    output logic              stk_full_o,
    output logic              stk_err_o,
    input  logic              err_clr_i
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [2:0] {
        COND_AL = 3'd0,
        COND_EQ = 3'd1,
        COND_NE = 3'd2,
        COND_CS = 3'd3,
        COND_CC = 3'd4,
        COND_MI = 3'd5,
        COND_PL = 3'd6,
        COND_NV = 3'd7
    } cond_e;

    logic [APSR_W-1:0] psr_q, psr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [APSR_W-1:0] stk_q [DEPTH];
    logic [APSR_W-1:0] stk_d [DEPTH];
    logic              err_q, err_d;
    logic              br_valid_q, br_valid_d;
    logic              br_taken_q, br_taken_d;

    logic              stk_empty;
    logic              stk_full;
    logic              both_req;
    logic              push_ok;
    logic              pop_ok;
    logic              err_evt;
    logic [APSR_W-1:0] top_entry;
    logic              cond_true;

    // Request classification; a simultaneous save+restore is neither a push nor a pop
    always_comb begin
        stk_empty = (cnt_q == '0);
        stk_full  = (cnt_q == CNT_W'(DEPTH));
        both_req  = irq_save_i & irq_restore_i;
        push_ok   = irq_save_i & ~irq_restore_i & ~stk_full;
        pop_ok    = irq_restore_i & ~irq_save_i & ~stk_empty;
        err_evt   = both_req
                  | (irq_save_i & ~irq_restore_i & stk_full)
                  | (irq_restore_i & ~irq_save_i & stk_empty);
    end

    always_comb begin
        top_entry = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == cnt_q) begin
                top_entry = stk_q[i];
            end
        end
    end

    // The push captures the registered PSR, never the value being written this cycle
    always_comb begin
        stk_d = stk_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && (CNT_W'(i) == cnt_q)) begin
                stk_d[i] = psr_q;
            end
        end
        cnt_d = cnt_q;
        if (push_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_comb begin
        psr_d = psr_q;
        if (pop_ok) begin
            psr_d = top_entry;
        end else if (apsr_we_i) begin
            psr_d = apsr_i;
        end

        err_d = err_q;
        if (err_evt) begin
            err_d = 1'b1;
        end else if (err_clr_i) begin
            err_d = 1'b0;
        end
    end

    // Branch conditions see psr_d so a flag-setting op and its branch can share a cycle
    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(br_cond_i))
            COND_AL: cond_true = 1'b1;
            COND_EQ: cond_true = psr_d[`APSR_ZERO];
            COND_NE: cond_true = ~psr_d[`APSR_ZERO];
            COND_CS: cond_true = psr_d[`APSR_CARRY];
            COND_CC: cond_true = ~psr_d[`APSR_CARRY];
            COND_MI: cond_true = psr_d[`APSR_NEG];
            COND_PL: cond_true = ~psr_d[`APSR_NEG];
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
        br_valid_d = br_req_i;
        br_taken_d = br_req_i & cond_true;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psr_q      <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            br_valid_q <= 1'b0;
            br_taken_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
        end else begin
            psr_q      <= psr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            br_valid_q <= br_valid_d;
            br_taken_q <= br_taken_d;
            for (int i = 0; i < DEPTH; i++) begin
                stk_q[i] <= stk_d[i];
            end
        end
    end

    assign psr_o       = psr_q;
    assign br_valid_o  = br_valid_q;
    assign br_taken_o  = br_taken_q;
    assign stk_empty_o = stk_empty;
    assign stk_full_o  = stk_full;
    assign stk_err_o   = err_q;

endmodule

// File: tb/tb_psr_unit.sv
// Bench for psr_unit: directed scenarios then random traffic against a queue-based flag/stack model.
module tb_psr_unit;

    localparam int DEPTH = 2;
    localparam logic [2:0] AL = 3'd0, EQ = 3'd1, NE = 3'd2, CS = 3'd3;
    localparam logic [2:0] CC = 3'd4, MI = 3'd5, PL = 3'd6, NV = 3'd7;
    localparam logic [2:0] F_C = 3'b001, F_Z = 3'b010, F_N = 3'b100;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] apsr_i;
    logic       apsr_we_i;
    logic [2:0] psr_o;
    logic       br_req_i;
    logic [2:0] br_cond_i;
    logic       br_valid_o;
    logic       br_taken_o;
    logic       irq_save_i;
    logic       irq_restore_i;
    logic       stk_empty_o;
    logic       stk_full_o;
    logic       stk_err_o;
    logic       err_clr_i;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] m_psr;
    logic [2:0] m_stk[$];
    logic       m_err, m_bv, m_bt;

    psr_unit #(.APSR_W(3), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .apsr_i       (apsr_i),
        .apsr_we_i    (apsr_we_i),
        .psr_o        (psr_o),
        .br_req_i     (br_req_i),
        .br_cond_i    (br_cond_i),
        .br_valid_o   (br_valid_o),
        .br_taken_o   (br_taken_o),
        .irq_save_i   (irq_save_i),
        .irq_restore_i(irq_restore_i),
        .stk_empty_o  (stk_empty_o),
        .stk_full_o   (stk_full_o),
        .stk_err_o    (stk_err_o),
        .err_clr_i    (err_clr_i)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    function automatic logic cond_true(input logic [2:0] p, input logic [2:0] c);
        logic cf, zf, nf;
        cf = p[0];
        zf = p[1];
        nf = p[2];
        case (c)
            AL:      return 1'b1;
            EQ:      return zf;
            NE:      return !zf;
            CS:      return cf;
            CC:      return !cf;
            MI:      return nf;
            PL:      return !nf;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".psr"},   {5'd0, psr_o},       {5'd0, m_psr});
        chk({tag, ".bv"},    {7'd0, br_valid_o},  {7'd0, m_bv});
        chk({tag, ".bt"},    {7'd0, br_taken_o},  {7'd0, m_bt});
        chk({tag, ".empty"}, {7'd0, stk_empty_o}, {7'd0, (m_stk.size() == 0)});
        chk({tag, ".full"},  {7'd0, stk_full_o},  {7'd0, (m_stk.size() == DEPTH)});
        chk({tag, ".err"},   {7'd0, stk_err_o},   {7'd0, m_err});
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".psr"},   {5'd0, psr_o},       8'd0);
        chk({tag, ".bv"},    {7'd0, br_valid_o},  8'd0);
        chk({tag, ".bt"},    {7'd0, br_taken_o},  8'd0);
        chk({tag, ".empty"}, {7'd0, stk_empty_o}, 8'd1);
        chk({tag, ".full"},  {7'd0, stk_full_o},  8'd0);
        chk({tag, ".err"},   {7'd0, stk_err_o},   8'd0);
    endtask

    task automatic model_reset();
        m_psr = '0;
        m_stk.delete();
        m_err = 1'b0;
        m_bv  = 1'b0;
        m_bt  = 1'b0;
    endtask

    // Drives one cycle of inputs, advances the model, clocks, then checks every output
    task automatic cyc(input string tag, input logic [2:0] a, input logic we, input logic req,
                       input logic [2:0] cond, input logic sv, input logic rs, input logic clr);
        logic evt;
        logic popped;
        apsr_i        = a;
        apsr_we_i     = we;
        br_req_i      = req;
        br_cond_i     = cond;
        irq_save_i    = sv;
        irq_restore_i = rs;
        err_clr_i     = clr;
        evt    = 1'b0;
        popped = 1'b0;
        if (sv && rs) begin
            evt = 1'b1;
        end else if (sv) begin
            if (m_stk.size() == DEPTH) evt = 1'b1;
            else m_stk.push_back(m_psr);
        end else if (rs) begin
            if (m_stk.size() == 0) evt = 1'b1;
            else begin
                m_psr  = m_stk.pop_back();
                popped = 1'b1;
            end
        end
        if (!popped && we) m_psr = a;
        if (evt) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
        m_bv = req;
        m_bt = req && cond_true(m_psr, cond);
        @(posedge clk);
        #1;
        chk_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        apsr_i = '0; apsr_we_i = 0; br_req_i = 0; br_cond_i = '0;
        irq_save_i = 0; irq_restore_i = 0; err_clr_i = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst_n = 1'b1;

        // Branch basics from reset state
        cyc("br_eq", 3'd0, 0, 1, EQ, 0, 0, 0);
        chk("br_eq_taken", {7'd0, br_taken_o}, 8'd0);
        cyc("br_al", 3'd0, 0, 1, AL, 0, 0, 0);
        chk("br_al_taken", {7'd0, br_taken_o}, 8'd1);
        cyc("br_nv", 3'd0, 0, 1, NV, 0, 0, 0);
        cyc("idle0", 3'd0, 0, 0, AL, 0, 0, 0);
        chk("valid_one_cycle", {7'd0, br_valid_o}, 8'd0);

        // Forwarding of a same-cycle flag write into the condition
        cyc("fwd_eq", F_Z, 1, 1, EQ, 0, 0, 0);
        chk("fwd_eq_taken", {7'd0, br_taken_o}, 8'd1);
        chk("fwd_psr", {5'd0, psr_o}, {5'd0, F_Z});
        cyc("fwd_ne", F_Z, 1, 1, NE, 0, 0, 0);
        cyc("fwd_mi", F_N, 1, 1, MI, 0, 0, 0);
        cyc("fwd_pl", F_N, 0, 1, PL, 0, 0, 0);

        // Save/restore round trip
        cyc("set_c", F_C, 1, 0, AL, 0, 0, 0);
        cyc("save_we", F_N, 1, 0, AL, 1, 0, 0);
        chk("save_we_psr", {5'd0, psr_o}, {5'd0, F_N});
        cyc("rest_cs", 3'd0, 0, 1, CS, 0, 1, 0);
        chk("rest_cs_taken", {7'd0, br_taken_o}, 8'd1);
        chk("rest_psr", {5'd0, psr_o}, {5'd0, F_C});

        // Stack boundaries: overflow, LIFO order, underflow, clear
        cyc("sv1", F_Z, 1, 0, AL, 1, 0, 0);
        cyc("sv2", F_N, 1, 0, AL, 1, 0, 0);
        chk("sv2_full", {7'd0, stk_full_o}, 8'd1);
        cyc("sv3", 3'b111, 1, 1, CC, 1, 0, 0);
        chk("sv3_err", {7'd0, stk_err_o}, 8'd1);
        cyc("rs1", 3'd0, 0, 1, EQ, 0, 1, 0);
        chk("rs1_lifo", {5'd0, psr_o}, {5'd0, F_Z});
        cyc("rs2", 3'd0, 0, 1, CC, 0, 1, 0);
        chk("rs2_lifo", {5'd0, psr_o}, {5'd0, F_C});
        cyc("rs3", 3'd0, 0, 0, AL, 0, 1, 0);
        chk("rs3_hold", {5'd0, psr_o}, {5'd0, F_C});
        cyc("clr", 3'd0, 0, 0, AL, 0, 0, 1);
        chk("clr_err", {7'd0, stk_err_o}, 8'd0);

        // Illegal simultaneous save+restore, then clear racing a new underflow
        cyc("sv_one", F_N, 1, 0, AL, 1, 0, 0);
        cyc("both", F_Z, 1, 0, AL, 1, 1, 0);
        chk("both_err", {7'd0, stk_err_o}, 8'd1);
        chk("both_cnt", {6'd0, stk_full_o, stk_empty_o}, 8'd0);
        cyc("drain", 3'd0, 0, 0, AL, 0, 1, 0);
        cyc("clr_uf", F_C, 1, 1, CS, 0, 1, 1);
        chk("clr_uf_err", {7'd0, stk_err_o}, 8'd1);
        cyc("clr2", 3'd0, 0, 0, AL, 0, 0, 1);

        // Asynchronous reset between edges with two entries stacked
        cyc("pre_a", F_Z, 1, 0, AL, 1, 0, 0);
        cyc("pre_b", F_N, 1, 1, MI, 1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        chk_reset_vals("rst_held");
        rst_n = 1'b1;
        cyc("post_rst_rs", 3'd0, 0, 1, AL, 0, 1, 0);
        cyc("post_rst_clr", 3'd0, 0, 0, AL, 0, 0, 1);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            cyc("rand",
                3'($urandom_range(0, 7)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 9) < 3),
                ($urandom_range(0, 7) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
